// File: rtl/jk_counter_ctrl_pkg.sv
// Shared op codes and FSM encoding for the JK counter sequencer.
package jk_ctrl_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_UP   = 2'b10,
        OP_DOWN = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/jk_counter_ctrl_if.sv
// Command channel (valid/ready) between a command source and the sequencer.
interface jk_counter_ctrl_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LEN_W = 8
);
    import jk_ctrl_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [OP_W-1:0]  cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [LEN_W-1:0] cmd_len;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_len,
        output cmd_ready
    );

endinterface

// File: rtl/jk_counter_ctrl_cell.sv
// Single behavioural JK flip-flop cell.
module jk_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);

    // JK rule: set on J, clear on K, toggle on both, hold on neither
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= (j & ~q) | (~k & q);
        end
    end

endmodule

// File: rtl/jk_counter_ctrl.sv
// Sequencer driving a bank of JK cells: load / count up / count down / no-op.
module jk_counter_ctrl
    import jk_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    jk_counter_ctrl_if.slave cmd,
    input  logic             abort,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    state_e           state_q, state_nxt;
    op_e              op_q;
    logic [WIDTH-1:0] data_q;
    logic [LEN_W-1:0] rem_q, rem_nxt;
    logic             accept_c;
    logic             wrap_c;
    logic [WIDTH-1:0] t_up_c;
    logic [WIDTH-1:0] t_dn_c;

    assign cmd.cmd_ready = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign accept_c      = cmd.cmd_valid && (state_q == ST_IDLE);

    // Toggle masks: the bits that flip on an increment / decrement of q
    assign t_up_c = q ^ (q + WIDTH'(1));
    assign t_dn_c = q ^ (q - WIDTH'(1));

    // Next-state, remaining-step count and J/K drive
    always_comb begin
        state_nxt = state_q;
        rem_nxt   = rem_q;
        j_out     = '0;
        k_out     = '0;
        wrap_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    case (op_e'(cmd.cmd_op))
                        OP_LOAD: state_nxt = ST_LOAD;
                        OP_UP, OP_DOWN: begin
                            if (cmd.cmd_len != '0) begin
                                state_nxt = ST_RUN;
                                rem_nxt   = cmd.cmd_len;
                            end else begin
                                state_nxt = ST_DONE;
                            end
                        end
                        default: state_nxt = ST_DONE;
                    endcase
                end
            end
            ST_LOAD: begin
                j_out     = data_q;
                k_out     = ~data_q;
                state_nxt = ST_DONE;
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_DONE;
                end else begin
                    if (op_q == OP_UP) begin
                        j_out  = t_up_c;
                        k_out  = t_up_c;
                        wrap_c = &q;
                    end else begin
                        j_out  = t_dn_c;
                        k_out  = t_dn_c;
                        wrap_c = ~|q;
                    end
                    rem_nxt = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register, latched command, done/tc pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            data_q  <= '0;
            rem_q   <= '0;
            done    <= 1'b0;
            tc      <= 1'b0;
        end else begin
            state_q <= state_nxt;
            rem_q   <= rem_nxt;
            done    <= (state_nxt == ST_DONE);
            tc      <= wrap_c;
            if (accept_c) begin
                op_q   <= op_e'(cmd.cmd_op);
                data_q <= cmd.cmd_data;
            end
        end
    end

    // JK register bank
    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (j_out[i]),
            .k     (k_out[i]),
            .q     (q[i])
        );
    end

endmodule

// File: doc/jk_counter_ctrl.md
Name: jk_counter_ctrl

Overview:
- Sequencer for a bank of WIDTH JK flip-flop cells.
- Accepts one command at a time over a valid/ready handshake: load, count up, count down, or no-op.
- Drives each cell's J/K inputs cycle by cycle; cell outputs form the counter value q.
- Sits between a command source and the JK register bank; exposes J/K vectors for observability.

Parameters:
- WIDTH, 4, number of JK cells (counter width), ≥1.
- LEN_W, 8, width of the step-count field.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 NOP, 01 LOAD, 10 UP, 11 DOWN.
- cmd_data  in  WIDTH  load value (LOAD only).
- cmd_len  in  LEN_W  number of count steps (UP/DOWN only).
- abort  in  1  terminate a running count.
- j_out  out  WIDTH  J vector applied to cells this cycle.
- k_out  out  WIDTH  K vector applied to cells this cycle.
- q  out  WIDTH  JK bank outputs.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- tc  out  1  one-cycle wrap pulse.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset (async assert, sync-safe release):
  - q=0, state=IDLE, done=0, tc=0, j_out=k_out=0, busy=0.
  - cmd_ready reads 1 while rst_n low, but nothing is accepted while reset is asserted.
- Cell rule, per bit, each edge: q_next = (J & ~q) | (~K & q). J=K=0 holds.
- J/K generation (combinational from state, latched op, q, abort):
  - IDLE or DONE: J=K=0.
  - LOAD: J=data, K=~data.
  - UP: J=K=t, with t[0]=1 and t[i]=&q[i-1:0].
  - DOWN: J=K=t, with t[0]=1 and t[i]=&~q[i-1:0].
  - RUN with abort=1: J=K=0, so no step that cycle.
- Handshake:
  - cmd_ready = (state==IDLE).
  - Accept when cmd_valid & cmd_ready at an edge (E0); op/data/len are latched at E0.
  - cmd_valid while busy is ignored; no queueing.
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE --accept LOAD--> LOAD.
  - IDLE --accept UP/DOWN, len>0--> RUN; remaining=len.
  - IDLE --accept NOP, or UP/DOWN with len=0--> DONE; q unchanged.
  - LOAD --edge--> DONE; q=data after that edge (E1).
  - RUN at each edge with abort=0: q steps once, remaining decrements; if remaining==1, go to DONE.
  - RUN at an edge with abort=1: go to DONE, no step.
  - DONE --edge--> IDLE; done=1 for exactly the DONE cycle.
- Latency:
  - LOAD: done during cycle E1–E2; ready again after E2.
  - Count of L steps: L steps complete at E_L; done during E_L–E_L+1.
  - Zero-step commands: done during E0–E1.
- tc:
  - Registered; high for the one cycle after an edge where UP took q from all-ones to 0, or DOWN took q from 0 to all-ones.
  - LOAD never raises tc.
- Width rules: counting wraps modulo 2^WIDTH; remaining is LEN_W bits; cmd_len=2^LEN_W-1 is legal.
- Reset mid-operation: all of the above cleared immediately; the in-flight command is lost with no done pulse.
- abort outside RUN: no effect.

Decomposition:
- Shared package jk_ctrl_pkg:
  - op codes OP_NOP/OP_LOAD/OP_UP/OP_DOWN.
  - FSM state encoding ST_IDLE/ST_LOAD/ST_RUN/ST_DONE.
- One sub-module, jk_cell: single behavioural JK flop with clk and async active-low rst_n, reset q=0. Instantiated WIDTH times via generate.
- The controller holds the FSM, remaining counter, latched command, J/K logic, and tc/done registers.

Test Plan (WIDTH=4, LEN_W=8):
- Reset, then LOAD data=4'hA → q=4'hA after E1; done high one cycle (E1–E2); cmd_ready=0 from E0 until E2; tc stays 0.
- LOAD 4'hE, then UP len=3 → q sequence 4'hF, 4'h0, 4'h1 on successive edges; tc high one cycle right after the F→0 edge; done after the third step.
- LOAD 4'h1, then DOWN len=2 → q = 4'h0, then 4'hF; tc high one cycle after the 0→F edge; j_out=k_out=4'hF on the second step.
- UP len=0 and NOP (each preceded by LOAD 4'h5) → q stays 4'h5; done during E0–E1; no tc.
- LOAD 0, UP len=10, abort=1 on the 4th RUN edge → q=4'h3, DONE next, done pulse.
- Same run with cmd_valid pulsed while busy → ignored.
- rst_n driven low mid-RUN, asynchronously between edges → q=0, busy=0, done=0 immediately. After release, a fresh LOAD 4'h7 completes normally.
